// File: rtl/player_input_arbiter.sv
// rtl/player_input_arbiter.sv - buzzer sync/debounce, first-buzz arbitration and game-state handshake
module player_input_arbiter #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       btn,
  input  logic [7:0]       switches,
  input  logic [2:0]       gameStatus,
  input  logic [WIDTH-1:0] p1,
  input  logic [WIDTH-1:0] p2,
  input  logic [WIDTH-1:0] p3,
  input  logic [WIDTH-1:0] p4,
  output logic [1:0]       firstPlayerFlag,
  output logic             playerInputFlag,
  output logic [7:0]       switchInput,
  output logic             allButtons,
  output logic             gameHasStarted,
  output logic [1:0]       screenStatus,
  output logic [1:0]       winnerPlayerNum
);

  typedef enum logic [2:0] {IDLE, READY, ARMED, LOCKED, OVER} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [3:0]       btn_s1, btn_s, db, db_q;
  logic [7:0]       sw_s1, sw_s;
  logic [CNT_W-1:0] cnt [4];
  logic             all_q;
  logic [3:0]       rise;
  logic             all_rise;
  logic [1:0]       first_idx;
  logic [1:0]       best_idx;
  logic [WIDTH-1:0] best_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= '0;
      btn_s  <= '0;
      sw_s1  <= '0;
      sw_s   <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s  <= btn_s1;
      sw_s1  <= switches;
      sw_s   <= sw_s1;
    end
  end

  // A level is accepted only after it differs from db for DEBOUNCE_CYCLES straight cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db    <= '0;
      db_q  <= '0;
      all_q <= 1'b0;
      allButtons <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      db_q       <= db;
      allButtons <= &db;
      all_q      <= allButtons;
      for (int i = 0; i < 4; i++) begin
        if (btn_s[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= btn_s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise     = db & ~db_q;
  assign all_rise = allButtons & ~all_q;

  always_comb begin
    first_idx = 2'd0;
    if (rise[3]) first_idx = 2'd3;
    if (rise[2]) first_idx = 2'd2;
    if (rise[1]) first_idx = 2'd1;
    if (rise[0]) first_idx = 2'd0;
  end

  // Strict greater-than keeps ties on the lowest player index.
  always_comb begin
    best_idx = 2'd0;
    best_val = p1;
    if (p2 > best_val) begin best_idx = 2'd1; best_val = p2; end
    if (p3 > best_val) begin best_idx = 2'd2; best_val = p3; end
    if (p4 > best_val) begin best_idx = 2'd3; best_val = p4; end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      firstPlayerFlag <= '0;
      playerInputFlag <= 1'b0;
      switchInput     <= '0;
      gameHasStarted  <= 1'b0;
      screenStatus    <= '0;
      winnerPlayerNum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (all_rise) begin
            state          <= READY;
            gameHasStarted <= 1'b1;
            screenStatus   <= 2'd1;
          end
        end
        READY, ARMED, LOCKED: begin
          if (gameStatus == 3'd4) begin
            state           <= OVER;
            screenStatus    <= 2'd2;
            gameHasStarted  <= 1'b0;
            playerInputFlag <= 1'b0;
            winnerPlayerNum <= best_idx;
          end else if (state == READY) begin
            if (gameStatus == 3'd2) state <= ARMED;
          end else if (state == ARMED) begin
            if (|rise) begin
              firstPlayerFlag <= first_idx;
              switchInput     <= sw_s;
              playerInputFlag <= 1'b1;
              state           <= LOCKED;
            end
          end else if (gameStatus == 3'd3) begin
            playerInputFlag <= 1'b0;
            state           <= READY;
          end
        end
        OVER: begin
          if (all_rise) begin
            state           <= IDLE;
            screenStatus    <= 2'd0;
            winnerPlayerNum <= 2'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
